// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and constants for the DAC direct-mode streamer
package dac_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_STREAM} streamer_state_t;

  localparam int SAMPLE_WIDTH     = 16;
  localparam int SAMPLES_PER_WORD = 8;

endpackage

// File: rtl/dac_direct_streamer_if.sv
// rtl/dac_direct_streamer_if.sv - beat stream toward the RFDC DAC AXIS input
interface dac_direct_streamer_if #(
  parameter int DATA_WIDTH = 256
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/beat_fifo.sv
// rtl/beat_fifo.sv - single-clock beat FIFO with level output and registered read data
module beat_fifo #(
  parameter int WIDTH      = 256,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  wr_ok, rd_ok;

  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = rd_data_q;

  always_comb begin
    rd_ok     = rd_en && !empty && !flush;
    // A write into a full FIFO is only taken when a pop frees the slot this cycle.
    wr_ok     = wr_en && (!full || rd_ok) && !flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      level_d = level_q + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(rd_ok);
    end
    if (rd_ok) begin
      rd_data_d = mem[rd_ptr_q];
    end else if (rd_zero && !flush) begin
      rd_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/dac_direct_streamer.sv
// rtl/dac_direct_streamer.sv - packs timed words into beats and streams them to the DAC
module dac_direct_streamer
  import dac_pkg::*;
#(
  parameter int IN_WIDTH        = SAMPLE_WIDTH * SAMPLES_PER_WORD,
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PRIME_LEVEL     = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       clear_error,
  input  logic                       din_valid,
  input  logic [IN_WIDTH-1:0]        din,
  dac_direct_streamer_if.master      m_axis,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_level,
  output logic                       streaming,
  output logic                       underflow_error,
  output logic                       overflow_error
);

  localparam logic [FIFO_ADDR_WIDTH:0] PRIME_L = (FIFO_ADDR_WIDTH+1)'(PRIME_LEVEL);

  streamer_state_t              state_q, state_d;
  logic                         half_q, half_d;
  logic [IN_WIDTH-1:0]          low_q, low_d;
  logic [AXIS_DATA_WIDTH-1:0]   beat_q, beat_d;
  logic                         beat_vld_q, beat_vld_d;
  logic                         tvalid_q, tvalid_d;
  logic                         stop_pend_q, stop_pend_d;
  logic                         uf_q, uf_d;
  logic                         of_q, of_d;

  logic                         pop, load_zero, uf_evt, of_evt, upd, level_ok;
  logic                         fifo_full, fifo_empty;
  logic [FIFO_ADDR_WIDTH:0]     fifo_lvl;
  logic [AXIS_DATA_WIDTH-1:0]   fifo_rd_data;

  beat_fifo #(
    .WIDTH      (AXIS_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (flush),
    .wr_en   (beat_vld_q),
    .wr_data (beat_q),
    .rd_en   (pop),
    .rd_zero (load_zero),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_lvl)
  );

  // The FIFO read register doubles as the output data register.
  assign m_axis.tdata    = fifo_rd_data;
  assign m_axis.tvalid   = tvalid_q;
  assign fifo_level      = fifo_lvl;
  assign streaming       = (state_q == ST_STREAM);
  assign underflow_error = uf_q;
  assign overflow_error  = of_q;

  always_comb begin
    half_d     = half_q;
    low_d      = low_q;
    beat_d     = beat_q;
    beat_vld_d = 1'b0;
    if (flush) begin
      half_d = 1'b0;
    end else if (din_valid) begin
      if (!half_q) begin
        low_d  = din;
        half_d = 1'b1;
      end else begin
        beat_d     = {din, low_q};
        beat_vld_d = 1'b1;
        half_d     = 1'b0;
      end
    end
  end

  always_comb begin
    upd         = m_axis.tready || !tvalid_q;
    level_ok    = (fifo_lvl >= PRIME_L);
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    stop_pend_d = stop_pend_q;
    pop         = 1'b0;
    load_zero   = 1'b0;
    uf_evt      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (level_ok) begin
            state_d  = ST_STREAM;
            tvalid_d = 1'b1;
            pop      = 1'b1;
          end else begin
            state_d = ST_PRIME;
          end
        end
      end
      ST_PRIME: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (level_ok) begin
          state_d  = ST_STREAM;
          tvalid_d = 1'b1;
          pop      = 1'b1;
        end
      end
      ST_STREAM: begin
        // A stop seen under backpressure waits until the presented beat is taken.
        if (upd) begin
          if (stop || stop_pend_q) begin
            state_d     = ST_IDLE;
            tvalid_d    = 1'b0;
            stop_pend_d = 1'b0;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            load_zero = 1'b1;
            uf_evt    = 1'b1;
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d     = ST_IDLE;
      tvalid_d    = 1'b0;
      stop_pend_d = 1'b0;
      pop         = 1'b0;
      load_zero   = 1'b0;
      uf_evt      = 1'b0;
    end
  end

  always_comb begin
    of_evt = beat_vld_q && fifo_full && !pop && !flush;
    uf_d   = (uf_q && !clear_error) || uf_evt;
    of_d   = (of_q && !clear_error) || of_evt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      half_q      <= 1'b0;
      low_q       <= '0;
      beat_q      <= '0;
      beat_vld_q  <= 1'b0;
      tvalid_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      uf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      low_q       <= low_d;
      beat_q      <= beat_d;
      beat_vld_q  <= beat_vld_d;
      tvalid_q    <= tvalid_d;
      stop_pend_q <= stop_pend_d;
      uf_q        <= uf_d;
      of_q        <= of_d;
    end
  end

endmodule

// File: doc/dac_direct_streamer.md
Name: dac_direct_streamer

Overview:
Produces the direct-mode sample stream for the RFDC DAC AXIS input. This is the path selected when dac_mode = 1, in place of the DDS output.
- Consumes 128-bit timed words released by the RTO core: 8 samples x 16 bit, strobed by counter_matched.
- Packs pairs of words into 256-bit beats and buffers them in a FIFO.
- Streams the beats under a prime/stream state machine with underflow and overflow detection.
- Sits between RTO_Core output and the m00_axis_tdata_direct / m00_axis_tvalid_direct mux inputs.

Parameters:
IN_WIDTH, 128, width of one timed word from RTO core.
AXIS_DATA_WIDTH, 256, output beat width; must equal 2*IN_WIDTH.
FIFO_DEPTH, 16, beat FIFO depth; power of two.
FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH).
PRIME_LEVEL, 4, FIFO level required before leaving PRIME; range 1..FIFO_DEPTH.

Ports:
clk  in  1  single clock (rtio_clk domain)
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of packer, FIFO and state; errors are kept
start  in  1  pulse; arm playback
stop  in  1  pulse; end playback
clear_error  in  1  pulse; clear sticky error flags
din_valid  in  1  timed word strobe (counter_matched)
din  in  IN_WIDTH  timed word; sample k = din[16k+15:16k]
m_axis_tdata  out  AXIS_DATA_WIDTH  beat to RFDC
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  RFDC ready
fifo_level  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy, 0..FIFO_DEPTH
streaming  out  1  high in STREAM
underflow_error  out  1  sticky
overflow_error  out  1  sticky

Behaviour:
Reset values (resetn low, asynchronous):
- All outputs 0; state IDLE; packer half-flag 0; FIFO pointers 0.

Packer:
- First din_valid word is latched as the low half; half-flag set.
- Second word forms the beat {din, low_half}. That beat is written to the FIFO on the next clock edge; half-flag clears.
- Packing runs in every state.

FIFO write and overflow:
- A write attempted when the FIFO is full drops the beat and sets overflow_error.
- A simultaneous read and write when full is legal and does not overflow.

Latency:
- Second word accepted at cycle N -> FIFO written at N+1 -> beat on m_axis_tdata no earlier than N+2 when in STREAM.

Output register:
- m_axis_tdata/m_axis_tvalid are registered.
- They update only when m_axis_tready = 1 or m_axis_tvalid = 0.
- tdata is held stable while tvalid = 1 and tready = 0.

States:
- IDLE:
  - tvalid = 0; FIFO fills.
  - start -> PRIME; if fifo_level >= PRIME_LEVEL at that cycle, go directly to STREAM.
- PRIME:
  - tvalid = 0.
  - fifo_level >= PRIME_LEVEL -> STREAM.
  - stop -> IDLE.
- STREAM:
  - tvalid = 1 continuously; streaming = 1.
  - On each output update: FIFO non-empty -> pop a beat into the output register; FIFO empty -> load all-zero beat and set underflow_error.
  - stop -> IDLE at the next output update; the beat currently presented completes.
  - FIFO contents are kept.

Simultaneous events:
- flush has priority over start/stop. flush -> IDLE, FIFO emptied, half-flag cleared (an odd pending word is discarded), tvalid = 0.
- start and stop in the same cycle: stop wins.
- start while in PRIME or STREAM is ignored.
- clear_error coinciding with a new error event: the flag stays set.

Pointers and arithmetic:
- Pointers are FIFO_ADDR_WIDTH bits and wrap modulo FIFO_DEPTH.
- Full/empty come from the level counter; the level never exceeds FIFO_DEPTH.

Decomposition:
- Shared package dac_pkg:
  - typedef enum logic[1:0] {ST_IDLE, ST_PRIME, ST_STREAM} streamer_state_t
  - localparam SAMPLE_WIDTH = 16
  - localparam SAMPLES_PER_WORD = 8
- Sub-module beat_fifo: synchronous single-clock FIFO with level output; no prefetch; read data valid the cycle after a pop.
- Top module contains the packer, FSM, output register and error flags.

Test Plan:
1. Reset/idle check
   - Stimulus: assert resetn = 0 mid-stream, then release.
   - Required: all outputs 0; fifo_level = 0; no tvalid until start and priming complete.
2. Pack and prime
   - Stimulus: push 8 words with din = word index replicated in every sample (0x0000..0x0007); then start; tready = 1.
   - Required: fifo_level reaches 4; STREAM entered.
   - Required: beats appear in order with tdata[127:0] = word 2i and tdata[255:128] = word 2i+1.
3. Backpressure
   - Stimulus: in STREAM, hold tready = 0 for 5 cycles.
   - Required: tdata stable throughout; no beat lost or duplicated; order preserved.
4. Underflow
   - Stimulus: prime with exactly 4 beats; tready = 1; no further input.
   - Required: beat 5 onward is all zero with tvalid = 1; underflow_error = 1 until clear_error.
5. Overflow
   - Stimulus: in IDLE, push 34 words (17 beats) into the 16-deep FIFO.
   - Required: fifo_level = 16; overflow_error = 1; streamed data is beats 0..15 only.
6. Flush with odd word
   - Stimulus: push 3 words, flush, then push words A and B.
   - Required: first beat after start+prime is {B, A}; the odd pending word is discarded.
